// File: rtl/cube_move_sequencer.sv
// Cube-move controller: owns the 162-bit cube, sequences move/undo/redo/scramble commands
// through an external combinational move engine and reports solved state and history counters.
module cube_move_sequencer #(
    parameter int unsigned HIST_DEPTH   = 64,
    parameter int unsigned SCRAMBLE_LEN = 30,
    parameter int unsigned CNT_W        = 10,
    parameter int unsigned CNT_MAX      = 999,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [2:0]                   cmd_face,
    input  logic [1:0]                   cmd_rot,
    output logic [2:0]                   eng_face,
    output logic [2:0]                   eng_rot,
    input  logic [161:0]                 eng_next,
    output logic [161:0]                 cube_state,
    output logic                         solved,
    output logic [CNT_W-1:0]             move_count,
    output logic [$clog2(HIST_DEPTH):0]  hist_count,
    output logic [$clog2(HIST_DEPTH):0]  redo_count,
    output logic                         busy
);

    localparam int unsigned PTR_W  = $clog2(HIST_DEPTH);
    localparam int unsigned HC_W   = PTR_W + 1;
    localparam int unsigned CUBE_W = 162;

    localparam logic [1:0] OP_MOVE     = 2'd0;
    localparam logic [1:0] OP_UNDO     = 2'd1;
    localparam logic [1:0] OP_REDO     = 2'd2;
    localparam logic [1:0] OP_SCRAMBLE = 2'd3;

    // Sticker i carries colour i/9 in the solved cube.
    function automatic logic [CUBE_W-1:0] solved_pattern();
        logic [CUBE_W-1:0] p;
        p = '0;
        for (int i = 0; i < 54; i++) begin
            p[3*i +: 3] = 3'(i / 9);
        end
        return p;
    endfunction

    localparam logic [CUBE_W-1:0] SOLVED = solved_pattern();

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_SCRAMBLE,
        S_CHECK
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_nxt;
    logic [7:0]        scr_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  ptr_dec;
    logic [4:0]        hist_mem [HIST_DEPTH];
    logic [4:0]        undo_entry;
    logic [4:0]        redo_entry;
    logic              accept;
    logic              move_ok;
    logic              undo_ok;
    logic              redo_ok;
    logic [HC_W-1:0]   hist_inc;
    logic [CNT_W-1:0]  mc_inc;
    logic [CNT_W-1:0]  mc_dec;

    assign accept     = cmd_valid && cmd_ready;
    assign ptr_inc    = PTR_W'(wr_ptr + 1'b1);
    assign ptr_dec    = PTR_W'(wr_ptr - 1'b1);
    assign undo_entry = hist_mem[ptr_dec];
    assign redo_entry = hist_mem[wr_ptr];
    assign move_ok    = (cmd_op == OP_MOVE) && (cmd_rot != 2'd0) && (cmd_face < 3'd6);
    assign undo_ok    = (cmd_op == OP_UNDO) && (hist_count != '0);
    assign redo_ok    = (cmd_op == OP_REDO) && (redo_count != '0);
    assign lfsr_nxt   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // Saturating counter steps; a full history keeps its count while the oldest entry is overwritten.
    assign hist_inc = (hist_count == HC_W'(HIST_DEPTH)) ? hist_count : HC_W'(hist_count + 1'b1);
    assign mc_inc   = (move_count >= CNT_W'(CNT_MAX)) ? move_count : CNT_W'(move_count + 1'b1);
    assign mc_dec   = (move_count == '0) ? move_count : CNT_W'(move_count - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and engine request.
    always_comb begin
        state_nxt = state;
        eng_face  = 3'd0;
        eng_rot   = 3'd0;
        case (state)
            S_INIT: begin
                state_nxt = S_IDLE;
            end
            S_IDLE: begin
                case (cmd_op)
                    OP_MOVE: begin
                        eng_face = cmd_face;
                        eng_rot  = {1'b0, cmd_rot};
                    end
                    OP_UNDO: begin
                        eng_face = undo_entry[4:2];
                        eng_rot  = {1'b0, 2'(2'd0 - undo_entry[1:0])};
                    end
                    OP_REDO: begin
                        eng_face = redo_entry[4:2];
                        eng_rot  = {1'b0, redo_entry[1:0]};
                    end
                    default: ;
                endcase
                if (accept) begin
                    state_nxt = (cmd_op == OP_SCRAMBLE) ? S_SCRAMBLE : S_CHECK;
                end
            end
            S_SCRAMBLE: begin
                eng_face = (lfsr[2:0] > 3'd5) ? 3'(lfsr[2:0] - 3'd6) : lfsr[2:0];
                eng_rot  = {1'b0, (lfsr[4:3] == 2'd0) ? 2'd1 : lfsr[4:3]};
                if (scr_cnt == 8'(SCRAMBLE_LEN - 1)) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cube_state <= '0;
            solved     <= 1'b0;
            move_count <= '0;
            hist_count <= '0;
            redo_count <= '0;
            wr_ptr     <= '0;
            scr_cnt    <= '0;
            lfsr       <= LFSR_SEED;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
        end else begin
            lfsr      <= lfsr_nxt;
            cmd_ready <= (state_nxt == S_IDLE);
            busy      <= (state_nxt != S_IDLE);
            case (state)
                S_INIT: begin
                    cube_state <= SOLVED;
                    solved     <= 1'b1;
                end
                S_IDLE: begin
                    if (accept) begin
                        if (move_ok) begin
                            cube_state <= eng_next;
                            wr_ptr     <= ptr_inc;
                            hist_count <= hist_inc;
                            redo_count <= '0;
                            move_count <= mc_inc;
                        end else if (undo_ok) begin
                            cube_state <= eng_next;
                            wr_ptr     <= ptr_dec;
                            hist_count <= HC_W'(hist_count - 1'b1);
                            redo_count <= HC_W'(redo_count + 1'b1);
                            move_count <= mc_dec;
                        end else if (redo_ok) begin
                            cube_state <= eng_next;
                            wr_ptr     <= ptr_inc;
                            hist_count <= HC_W'(hist_count + 1'b1);
                            redo_count <= HC_W'(redo_count - 1'b1);
                            move_count <= mc_inc;
                        end else if (cmd_op == OP_SCRAMBLE) begin
                            wr_ptr     <= '0;
                            hist_count <= '0;
                            redo_count <= '0;
                            move_count <= '0;
                            scr_cnt    <= '0;
                        end
                    end
                end
                S_SCRAMBLE: begin
                    cube_state <= eng_next;
                    scr_cnt    <= 8'(scr_cnt + 1'b1);
                end
                S_CHECK: begin
                    solved <= (cube_state == SOLVED);
                end
                default: ;
            endcase
        end
    end

    // History storage; contents are only meaningful below hist_count/redo_count.
    always_ff @(posedge clk) begin
        if ((state == S_IDLE) && accept && move_ok) begin
            hist_mem[wr_ptr] <= {cmd_face, cmd_rot};
        end
    end

endmodule

// File: tb/tb_cube_move_sequencer.sv
// Scoreboard bench for cube_move_sequencer: a toy order-4 move engine drives eng_next, commands push
// expected post-command snapshots and a monitor compares them whenever cmd_ready returns high.
module tb_cube_move_sequencer;

    localparam int unsigned HD   = 4;
    localparam int unsigned SLEN = 30;
    localparam int unsigned CMAX = 6;
    localparam int unsigned CW   = 162;

    logic           clk;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [2:0]     cmd_face;
    logic [1:0]     cmd_rot;
    logic [2:0]     eng_face;
    logic [2:0]     eng_rot;
    logic [161:0]   eng_next;
    logic [161:0]   cube_state;
    logic           solved;
    logic [9:0]     move_count;
    logic [2:0]     hist_count;
    logic [2:0]     redo_count;
    logic           busy;

    typedef struct packed {
        logic [161:0] cube;
        logic         slv;
        logic [9:0]   mc;
        logic [2:0]   hc;
        logic [2:0]   rc;
        logic [7:0]   bz;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    cube_move_sequencer #(
        .HIST_DEPTH(HD), .SCRAMBLE_LEN(SLEN), .CNT_W(10), .CNT_MAX(CMAX), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_face(cmd_face), .cmd_rot(cmd_rot), .eng_face(eng_face), .eng_rot(eng_rot),
        .eng_next(eng_next), .cube_state(cube_state), .solved(solved), .move_count(move_count),
        .hist_count(hist_count), .redo_count(redo_count), .busy(busy)
    );

    function automatic logic [161:0] solved_cube();
        logic [161:0] p;
        p = '0;
        for (int i = 0; i < 54; i++) p[3*i +: 3] = 3'(i / 9);
        return p;
    endfunction

    // Toy engine: a quarter turn of face f 4-cycles three sticker slots across faces f..f+3.
    function automatic logic [161:0] engine(input logic [161:0] c, input logic [2:0] f, input logic [2:0] r);
        logic [161:0] x;
        logic [2:0]   t;
        int p0, p1, p2, p3;
        x = c;
        if (f < 3'd6) begin
            for (int q = 0; q < int'(r); q++) begin
                for (int k = 0; k < 3; k++) begin
                    p0 = 9 * ((int'(f) + 0) % 6) + 4 * k;
                    p1 = 9 * ((int'(f) + 1) % 6) + 4 * k;
                    p2 = 9 * ((int'(f) + 2) % 6) + 4 * k;
                    p3 = 9 * ((int'(f) + 3) % 6) + 4 * k;
                    t = x[3*p3 +: 3];
                    x[3*p3 +: 3] = x[3*p2 +: 3];
                    x[3*p2 +: 3] = x[3*p1 +: 3];
                    x[3*p1 +: 3] = x[3*p0 +: 3];
                    x[3*p0 +: 3] = t;
                end
            end
        end
        return x;
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    assign eng_next = engine(cube_state, eng_face, eng_rot);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Reference LFSR, free-running from reset like the sequencer's.
    logic [15:0] tl;
    always @(posedge clk) begin
        if (rst) tl <= 16'hACE1;
        else     tl <= lfsr_adv(tl);
    end

    task automatic chk(input string name, input logic [161:0] act, input logic [161:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Monitor: a rising cmd_ready marks a finished command.
    int   lowcnt = 0;
    logic prev_ready = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            lowcnt     = 0;
            prev_ready = 1'b0;
        end else begin
            if (!cmd_ready) begin
                lowcnt++;
            end else if (!prev_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", CW'(sb.size()), CW'(1));
                end else begin
                    e = sb.pop_front();
                    chk("sb_cube",   cube_state,        e.cube);
                    chk("sb_solved", CW'(solved),       CW'(e.slv));
                    chk("sb_moves",  CW'(move_count),   CW'(e.mc));
                    chk("sb_hist",   CW'(hist_count),   CW'(e.hc));
                    chk("sb_redo",   CW'(redo_count),   CW'(e.rc));
                    chk("sb_busy",   CW'(lowcnt),       CW'(e.bz));
                end
                lowcnt = 0;
            end
            prev_ready = cmd_ready;
        end
    end

    // Reference model state.
    logic [161:0] m_cube;
    logic [4:0]   m_hist [HD];
    int           m_wp, m_hc, m_rc, m_mc;

    task automatic model_reset();
        m_cube = solved_cube();
        m_wp = 0; m_hc = 0; m_rc = 0; m_mc = 0;
    endtask

    task automatic push_exp(input int bz);
        exp_t e;
        e.cube = m_cube;
        e.slv  = (m_cube == solved_cube());
        e.mc   = 10'(m_mc);
        e.hc   = 3'(m_hc);
        e.rc   = 3'(m_rc);
        e.bz   = 8'(bz);
        sb.push_back(e);
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [2:0] f, input logic [1:0] r);
        logic [4:0]  e;
        logic [15:0] l;
        logic [2:0]  sf;
        int bz;
        bz = 1;
        case (op)
            2'd0: if (r != 2'd0 && f < 3'd6) begin
                m_cube = engine(m_cube, f, {1'b0, r});
                m_hist[m_wp] = {f, r};
                m_wp = (m_wp + 1) % HD;
                m_hc = (m_hc < HD) ? m_hc + 1 : HD;
                m_rc = 0;
                m_mc = (m_mc < CMAX) ? m_mc + 1 : CMAX;
            end
            2'd1: if (m_hc > 0) begin
                m_wp = (m_wp + HD - 1) % HD;
                e = m_hist[m_wp];
                m_cube = engine(m_cube, e[4:2], 3'((4 - int'(e[1:0])) % 4));
                m_hc--; m_rc++;
                m_mc = (m_mc > 0) ? m_mc - 1 : 0;
            end
            2'd2: if (m_rc > 0) begin
                e = m_hist[m_wp];
                m_cube = engine(m_cube, e[4:2], {1'b0, e[1:0]});
                m_wp = (m_wp + 1) % HD;
                m_hc++; m_rc--;
                m_mc = (m_mc < CMAX) ? m_mc + 1 : CMAX;
            end
            default: begin
                m_wp = 0; m_hc = 0; m_rc = 0; m_mc = 0;
                l = tl;
                for (int s = 0; s < int'(SLEN); s++) begin
                    l  = lfsr_adv(l);
                    sf = (l[2:0] > 3'd5) ? 3'(l[2:0] - 3'd6) : l[2:0];
                    m_cube = engine(m_cube, sf, {1'b0, (l[4:3] == 2'd0) ? 2'd1 : l[4:3]});
                end
                bz = SLEN + 1;
            end
        endcase
        push_exp(bz);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        cmd_valid = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        chk("rst_cube",  cube_state,       CW'(0));
        chk("rst_ready", CW'(cmd_ready),   CW'(0));
        chk("rst_busy",  CW'(busy),        CW'(1));
        chk("rst_solved", CW'(solved),     CW'(0));
        chk("rst_cnts",  CW'({move_count, hist_count, redo_count}), CW'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        push_exp(1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] f, input logic [1:0] r, input int junk);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("issue_wait", CW'(cmd_ready), CW'(1));
            return;
        end
        model_cmd(op, f, r);
        cmd_valid = 1'b1; cmd_op = op; cmd_face = f; cmd_rot = r;
        @(posedge clk);
        #1;
        if (junk > 0) begin
            cmd_op = 2'd0; cmd_face = 3'd0; cmd_rot = 2'd1;
            repeat (junk) @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(cmd_ready && sb.size() == 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("idle_wait", CW'(sb.size()), CW'(0));
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_face = '0; cmd_rot = '0;
        model_reset();
        do_reset();
        wait_idle();

        // Move, undo back to solved, redo.
        issue(2'd0, 3'd0, 2'd1, 0);
        issue(2'd1, 3'd0, 2'd0, 0);
        wait_idle();
        chk("undo_solved_cube", cube_state, solved_cube());
        chk("undo_redo_cnt", CW'(redo_count), CW'(1));
        issue(2'd2, 3'd0, 2'd0, 0);
        wait_idle();
        chk("redo_moves", CW'(move_count), CW'(1));
        chk("redo_left",  CW'(redo_count), CW'(0));

        // Four quarter turns of one face restore the cube.
        do_reset();
        for (int i = 0; i < 4; i++) issue(2'd0, 3'd2, 2'd1, 0);
        wait_idle();
        chk("x4_solved", CW'(solved),     CW'(1));
        chk("x4_moves",  CW'(move_count), CW'(4));
        chk("x4_hist",   CW'(hist_count), CW'(4));

        // History overflow: six moves, five undos.
        do_reset();
        issue(2'd0, 3'd1, 2'd1, 0);
        issue(2'd0, 3'd3, 2'd2, 0);
        issue(2'd0, 3'd4, 2'd3, 0);
        issue(2'd0, 3'd5, 2'd1, 0);
        issue(2'd0, 3'd0, 2'd2, 0);
        issue(2'd0, 3'd2, 2'd3, 0);
        for (int i = 0; i < 5; i++) issue(2'd1, 3'd0, 2'd0, 0);
        wait_idle();
        chk("ovf_hist",  CW'(hist_count), CW'(0));
        chk("ovf_redo",  CW'(redo_count), CW'(4));
        chk("ovf_moves", CW'(move_count), CW'(2));
        issue(2'd2, 3'd0, 2'd0, 0);
        issue(2'd2, 3'd0, 2'd0, 0);
        issue(2'd0, 3'd1, 2'd3, 0);

        // Scramble with a command held during it, then a move, then a reset mid-scramble.
        issue(2'd3, 3'd0, 2'd0, 10);
        issue(2'd0, 3'd4, 2'd1, 0);
        wait_idle();
        chk("scr_then_move", CW'(move_count), CW'(1));
        issue(2'd3, 3'd0, 2'd0, 0);
        repeat (10) @(posedge clk);
        do_reset();
        wait_idle();

        // No-op commands, then saturation of move_count.
        issue(2'd1, 3'd0, 2'd0, 0);
        issue(2'd2, 3'd0, 2'd0, 0);
        issue(2'd0, 3'd1, 2'd0, 0);
        issue(2'd0, 3'd7, 2'd1, 0);
        issue(2'd0, 3'd6, 2'd2, 0);
        wait_idle();
        chk("noop_cube",  cube_state,       solved_cube());
        chk("noop_moves", CW'(move_count),  CW'(0));
        for (int i = 0; i < 8; i++) issue(2'd0, 3'(i % 6), 2'(1 + i % 3), 0);
        wait_idle();
        chk("sat_moves", CW'(move_count), CW'(CMAX));
        chk("sat_hist",  CW'(hist_count), CW'(4));

        repeat (3) @(negedge clk);
        chk("sb_drained", CW'(sb.size()), CW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
